// File: rtl/tdc_meas_sequencer_if.sv
// rtl/tdc_meas_sequencer_if.sv - result handshake bundle between the TDC sequencer and the digital core
//
// Purpose: carries one encoded delay measurement from the sequencer (master)
// to the consumer (slave) with a valid/ready handshake.
// Signals:
//   result        N_OUT  encoded delay count (0..N_TDC)
//   overflow      1      qualifies result: edge passed the whole chain
//   result_valid  1      result available
//   result_ready  1      consumer accepts result
interface tdc_meas_sequencer_if #(
  parameter int N_OUT = 6
);
  logic [N_OUT-1:0] result;
  logic             overflow;
  logic             result_valid;
  logic             result_ready;

  modport master (output result, output overflow, output result_valid, input result_ready);
  modport slave  (input result, input overflow, input result_valid, output result_ready);
endinterface

// File: rtl/tdc_meas_sequencer.sv
// rtl/tdc_meas_sequencer.sv - sequences one TDC delay-chain measurement per request
//
// Purpose: per request, presets the chain phase-reverse flops (first
// measurement after reset/disable only), launches an edge into the chain,
// waits max(settle_cyc,1) cycles, captures and encodes the flop vector to a
// run-length count, pulses the phase-reverse clock, then holds the result
// until the consumer accepts it.
// Ports:
//   clk, rstb          clock (posedge) and async active-low reset
//   en                 block enable; low aborts to IDLE and re-arms preset
//   start              measurement request, sampled in IDLE only
//   settle_cyc         settle length, sampled on leaving LAUNCH
//   tdc_therm          captured chain flops, bit0 = first delay unit
//   tdc_pstb           active-low preset to the phase-reverse flops
//   tdc_launch         chain input, toggles once per measurement
//   tdc_ph_rev_clk     one-cycle phase-reverse update pulse
//   busy               high in every state except IDLE
//   res                result/overflow/valid/ready handshake (master side)
module tdc_meas_sequencer #(
  parameter int N_TDC = 32,
  parameter int N_OUT = $clog2(N_TDC + 1),
  parameter int CYC_W = 8
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      en,
  input  logic                      start,
  input  logic [CYC_W-1:0]          settle_cyc,
  input  logic [N_TDC-1:0]          tdc_therm,
  output logic                      tdc_pstb,
  output logic                      tdc_launch,
  output logic                      tdc_ph_rev_clk,
  output logic                      busy,
  tdc_meas_sequencer_if.master      res
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESET, S_LAUNCH, S_SETTLE, S_CAPTURE, S_ROTATE, S_HOLD
  } state_t;

  state_t           state;
  logic             first_meas;
  logic             pol;
  logic [CYC_W-1:0] settle_cnt;

  logic [N_TDC-1:0] code;
  logic [N_OUT-1:0] run_len;
  logic             run;

  // The chain alternates launch polarity, so the captured vector is
  // normalised to "1 = edge passed" before counting. Only the unbroken run
  // of ones from bit0 counts; bubbles above the first zero are ignored.
  always_comb begin
    code    = tdc_therm ^ {N_TDC{~pol}};
    run_len = '0;
    run     = 1'b1;
    for (int i = 0; i < N_TDC; i++) begin
      if (run && code[i]) run_len = run_len + 1'b1;
      else                run     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state            <= S_IDLE;
      first_meas       <= 1'b1;
      pol              <= 1'b0;
      settle_cnt       <= '0;
      tdc_pstb         <= 1'b0;
      tdc_launch       <= 1'b0;
      tdc_ph_rev_clk   <= 1'b0;
      busy             <= 1'b0;
      res.result       <= '0;
      res.result_valid <= 1'b0;
      res.overflow     <= 1'b0;
    end else if (!en) begin
      // Abort: chain back into preset, next measurement presets again.
      // Launch level and last result are deliberately left alone.
      state            <= S_IDLE;
      first_meas       <= 1'b1;
      tdc_pstb         <= 1'b0;
      tdc_ph_rev_clk   <= 1'b0;
      busy             <= 1'b0;
      res.result_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          tdc_pstb <= 1'b1;
          if (start) begin
            busy <= 1'b1;
            if (first_meas) begin
              state    <= S_PRESET;
              tdc_pstb <= 1'b0;
            end else begin
              state <= S_LAUNCH;
            end
          end
        end
        S_PRESET: begin
          tdc_pstb   <= 1'b1;
          first_meas <= 1'b0;
          state      <= S_LAUNCH;
        end
        S_LAUNCH: begin
          tdc_launch <= ~tdc_launch;
          pol        <= ~tdc_launch;
          settle_cnt <= (settle_cyc == '0) ? CYC_W'(1) : settle_cyc;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_cnt <= CYC_W'(1)) state <= S_CAPTURE;
          else                         settle_cnt <= settle_cnt - 1'b1;
        end
        S_CAPTURE: begin
          res.result     <= run_len;
          res.overflow   <= &code;
          tdc_ph_rev_clk <= 1'b1;
          state          <= S_ROTATE;
        end
        S_ROTATE: begin
          tdc_ph_rev_clk   <= 1'b0;
          res.result_valid <= 1'b1;
          state            <= S_HOLD;
        end
        S_HOLD: begin
          if (res.result_ready) begin
            res.result_valid <= 1'b0;
            busy             <= 1'b0;
            state            <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_meas_sequencer.sv
// tb/tb_tdc_meas_sequencer.sv - randomized and directed self-checking bench for tdc_meas_sequencer
module tb_tdc_meas_sequencer;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        en = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  settle_cyc = 8'd0;
  logic [31:0] tdc_therm = 32'h0;
  logic        tdc_pstb, tdc_launch, tdc_ph_rev_clk, busy;

  tdc_meas_sequencer_if #(.N_OUT(6)) rif ();

  tdc_meas_sequencer #(.N_TDC(32), .N_OUT(6), .CYC_W(8)) dut (
    .clk            (clk),
    .rstb           (rstb),
    .en             (en),
    .start          (start),
    .settle_cyc     (settle_cyc),
    .tdc_therm      (tdc_therm),
    .tdc_pstb       (tdc_pstb),
    .tdc_launch     (tdc_launch),
    .tdc_ph_rev_clk (tdc_ph_rev_clk),
    .busy           (busy),
    .res            (rif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A measurement is a timeline counted from the accepting edge: position k
  // (cycles since acceptance). With p = 1 if a preset is due, the launch edge
  // leaves position p+1, capture leaves position p+2+S, the rotate pulse is
  // visible at p+3+S and the result is held from p+4+S until accepted.
  bit          m_active, m_first, m_en_last, m_launch, m_pol, m_ovf;
  int          m_k, m_p, m_s, m_res;

  function automatic int lead_ones(input logic [31:0] c);
    int n = 0;
    while (n < 32 && c[n]) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_active = 0; m_first = 1; m_en_last = 0; m_launch = 0; m_pol = 0;
    m_ovf = 0; m_k = 0; m_p = 0; m_s = 1; m_res = 0;
  endtask

  task automatic model_step();
    logic [31:0] c;
    if (!en) begin
      m_active = 0; m_first = 1; m_en_last = 0;
    end else begin
      m_en_last = 1;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_k = 1; m_p = m_first ? 1 : 0; m_first = 0;
        end
      end else begin
        if (m_k == m_p + 1) begin
          m_launch = ~m_launch;
          m_pol    = m_launch;
          m_s      = (settle_cyc == 0) ? 1 : int'(settle_cyc);
        end
        if (m_k == m_p + 2 + m_s) begin
          c     = tdc_therm ^ {32{~m_pol}};
          m_res = lead_ones(c);
          m_ovf = (c == 32'hFFFF_FFFF);
        end
        if (m_k >= m_p + 4 + m_s) begin
          if (rif.result_ready) m_active = 0;
        end else begin
          m_k++;
        end
      end
    end
  endtask

  initial model_reset();

  always @(posedge clk) begin
    if (!rstb) model_reset();
    else       model_step();
    #1;
    if (rstb) begin
      chk("busy",     busy,           m_active);
      chk("pstb",     tdc_pstb,       m_active ? !(m_p == 1 && m_k == 1) : m_en_last);
      chk("ph_rev",   tdc_ph_rev_clk, m_active && (m_k == m_p + 3 + m_s));
      chk("valid",    rif.result_valid, m_active && (m_k == m_p + 4 + m_s));
      chk("launch",   tdc_launch,     m_launch);
      chk("result",   rif.result,     m_res);
      chk("overflow", rif.overflow,   m_ovf);
    end
  end

  // ---------------- directed helpers ----------------
  // Pulse start, then return at the negedge where result_valid is first seen;
  // lat is the number of edges after the start-sampling edge.
  task automatic meas(input logic [7:0] s, input logic [31:0] th, output int lat);
    @(negedge clk);
    settle_cyc = s; tdc_therm = th; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!rif.result_valid && lat < 600) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    @(negedge clk); rif.result_ready = 1'b1;
    @(negedge clk); rif.result_ready = 1'b0;
    chk("valid_drop", rif.result_valid, 0);
    chk("busy_drop",  busy, 0);
  endtask

  int lat;

  initial begin
    rif.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pstb",   tdc_pstb, 0);
    chk("rst_launch", tdc_launch, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_valid",  rif.result_valid, 0);
    chk("rst_result", rif.result, 0);
    chk("rst_ovf",    rif.overflow, 0);
    rstb = 1'b1; en = 1'b1;
    repeat (2) @(negedge clk);

    // first measurement with preset
    meas(8'd4, 32'h0000_00FF, lat);
    chk("t1_lat", lat, 8);
    chk("t1_result", rif.result, 8);
    chk("t1_ovf", rif.overflow, 0);
    chk("t1_launch", tdc_launch, 1);
    release_result();

    // no preset, launch 1->0, pol=0
    meas(8'd4, 32'hFFFF_F000, lat);
    chk("t2_lat", lat, 7);
    chk("t2_result", rif.result, 12);
    chk("t2_launch", tdc_launch, 0);
    release_result();

    // bubble above the first zero, pol=1
    meas(8'd4, 32'h0000_0F37, lat);
    chk("t3_result", rif.result, 3);
    release_result();

    // pol=0: all-zero capture means the edge crossed the whole chain
    meas(8'd4, 32'h0000_0000, lat);
    chk("t3_full", rif.result, 32);
    chk("t3_ovf", rif.overflow, 1);
    // consumer stalls; start pulses are ignored meanwhile
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i % 3 == 0);
    end
    start = 1'b0;
    chk("t4_valid", rif.result_valid, 1);
    chk("t4_busy", busy, 1);
    chk("t4_result", rif.result, 32);
    release_result();

    // settle 0 behaves as 1, after a disable re-arms preset
    @(negedge clk); en = 1'b0;
    @(negedge clk); en = 1'b1;
    meas(8'd0, 32'h0000_0001, lat);
    chk("t5_lat0", lat, 5);
    release_result();
    meas(8'd255, 32'h0000_0003, lat);
    chk("t5_lat255", lat, 258);
    release_result();

    // abort during SETTLE
    @(negedge clk); settle_cyc = 8'd10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_pstb", tdc_pstb, 0);
    chk("t6_valid", rif.result_valid, 0);
    chk("t6_phrev", tdc_ph_rev_clk, 0);
    en = 1'b1;
    meas(8'd4, 32'h0000_FFFF, lat);
    chk("t6_lat", lat, 8);
    release_result();

    // async reset mid-measurement
    @(negedge clk); settle_cyc = 8'd6; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rstb = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_pstb", tdc_pstb, 0);
    chk("ar_launch", tdc_launch, 0);
    chk("ar_result", rif.result, 0);
    chk("ar_valid", rif.result_valid, 0);
    @(negedge clk); rstb = 1'b1;

    // randomized traffic, everything checked by the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      en               = ($urandom_range(0, 60) != 0);
      start            = ($urandom_range(0, 3) == 0);
      rif.result_ready = ($urandom_range(0, 1) == 1);
      settle_cyc       = 8'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0: tdc_therm = $urandom;
        1: begin
          int l = $urandom_range(0, 32);
          logic [63:0] t = (64'd1 << l) - 64'd1;
          tdc_therm = t[31:0];
        end
        2: begin
          int l = $urandom_range(0, 32);
          logic [63:0] t = (64'd1 << l) - 64'd1;
          tdc_therm = ~t[31:0];
        end
        default: tdc_therm = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'h0;
      endcase
    end
    @(negedge clk);
    start = 1'b0; en = 1'b1; rif.result_ready = 1'b1;
    repeat (30) @(negedge clk);
    chk("end_idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
